// File: rtl/alsu_operand_issue.sv
// Issue stage for the 4-bit ALSU adder: buffers requests, drives one operation at a time, holds the result.
// Optional completed-operation counter is built when ALSU_OP_COUNTER_EN is defined.
module alsu_operand_issue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  input  logic [4:0]       in_sel,
  output logic [3:0]       issue_a,
  output logic [3:0]       issue_b,
  output logic [4:0]       issue_sel,
  input  logic [3:0]       res_sum,
  input  logic             res_carry,
  input  logic             res_neg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_sum,
  output logic             out_carry,
  output logic             out_neg,
  output logic             out_zero,
  output logic [4:0]       out_sel,
  output logic [CNT_W-1:0] op_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] EXEC = 2'b01;
  localparam logic [1:0] HOLD = 2'b10;

  logic [12:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          empty;
  logic          push;
  logic          pop;
  logic [12:0]   head;

  assign empty    = (count == {(AW+1){1'b0}});
  assign in_ready = (count != FULL_CNT);
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr];

  // Next-state and pop decision; a pop always coincides with loading issue_*.
  always_comb begin
    pop       = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = EXEC;
        end else begin
          state_nxt = IDLE;
        end
      end
      EXEC: state_nxt = HOLD;
      HOLD: begin
        if (out_ready && !empty) begin
          pop       = 1'b1;
          state_nxt = EXEC;
        end else if (out_ready) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = HOLD;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_sel, in_b, in_a};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {(AW+1){1'b0}};
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Control state, issue registers and captured result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      issue_a   <= 4'h0;
      issue_b   <= 4'h0;
      issue_sel <= 5'h00;
      out_valid <= 1'b0;
      out_sum   <= 4'h0;
      out_carry <= 1'b0;
      out_neg   <= 1'b0;
      out_zero  <= 1'b1;
      out_sel   <= 5'h00;
    end else begin
      state <= state_nxt;
      if (pop) begin
        issue_a   <= head[3:0];
        issue_b   <= head[7:4];
        issue_sel <= head[12:8];
      end
      if (state == EXEC) begin
        out_valid <= 1'b1;
        out_sum   <= res_sum;
        out_carry <= res_carry;
        out_neg   <= res_neg;
        out_zero  <= (res_sum == 4'h0);
        out_sel   <= issue_sel;
      end else if ((state == HOLD) && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef ALSU_OP_COUNTER_EN
  // Completed-operation counter; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= {CNT_W{1'b0}};
    end else if (out_valid && out_ready) begin
      op_count <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end
`else
  assign op_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_alsu_operand_issue.sv
// Directed self-checking bench for alsu_operand_issue with a behavioural adder model (neg = sel[4]).
module tb_alsu_operand_issue;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic [4:0] in_sel;
  logic [3:0] issue_a;
  logic [3:0] issue_b;
  logic [4:0] issue_sel;
  logic [3:0] res_sum;
  logic       res_carry;
  logic       res_neg;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_sum;
  logic       out_carry;
  logic       out_neg;
  logic       out_zero;
  logic [4:0] out_sel;
  logic [1:0] op_count;

  logic       force_en;
  logic [3:0] force_sum;
  logic       force_carry;
  logic       force_neg;
  logic [4:0] add5;

  int checks = 0;
  int errors = 0;
  int hs = 0;
  int cyc = 0;
  int last_cyc;
  int wait_cnt;
  int accepted;
  bit acc;

  logic [3:0] t_a    [6];
  logic [3:0] t_b    [6];
  logic [4:0] t_sel  [6];
  logic [3:0] t_sum  [6];
  logic       t_cry  [6];
  logic       t_neg  [6];
  logic       t_zero [6];

  alsu_operand_issue #(.DEPTH(4), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
    .issue_a(issue_a), .issue_b(issue_b), .issue_sel(issue_sel),
    .res_sum(res_sum), .res_carry(res_carry), .res_neg(res_neg),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_carry(out_carry), .out_neg(out_neg),
    .out_zero(out_zero), .out_sel(out_sel), .op_count(op_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign add5      = {1'b0, issue_a} + {1'b0, issue_b};
  assign res_sum   = force_en ? force_sum   : add5[3:0];
  assign res_carry = force_en ? force_carry : add5[4];
  assign res_neg   = force_en ? force_neg   : issue_sel[4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef ALSU_OP_COUNTER_EN
    return 32'(n % 4);
`else
    return 32'd0 + 32'(n * 0);
`endif
  endfunction

  // Drive a request at a negedge; accepted at the following posedge if in_ready was high.
  task automatic push_req(input logic [3:0] a, input logic [3:0] b, input logic [4:0] sel, output bit ok);
    in_a = a; in_b = b; in_sel = sel; in_valid = 1'b1;
    if (in_ready) begin
      @(negedge clk);
      ok = 1'b1;
    end else begin
      repeat (2) @(negedge clk);
      ok = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    t_a[0]=4'h1; t_b[0]=4'h2; t_sel[0]=5'h01; t_sum[0]=4'h3; t_cry[0]=1'b0; t_neg[0]=1'b0; t_zero[0]=1'b0;
    t_a[1]=4'h8; t_b[1]=4'h8; t_sel[1]=5'h02; t_sum[1]=4'h0; t_cry[1]=1'b1; t_neg[1]=1'b0; t_zero[1]=1'b1;
    t_a[2]=4'hF; t_b[2]=4'h1; t_sel[2]=5'h03; t_sum[2]=4'h0; t_cry[2]=1'b1; t_neg[2]=1'b0; t_zero[2]=1'b1;
    t_a[3]=4'h7; t_b[3]=4'h6; t_sel[3]=5'h10; t_sum[3]=4'hD; t_cry[3]=1'b0; t_neg[3]=1'b1; t_zero[3]=1'b0;
    t_a[4]=4'hA; t_b[4]=4'h7; t_sel[4]=5'h04; t_sum[4]=4'h1; t_cry[4]=1'b1; t_neg[4]=1'b0; t_zero[4]=1'b0;
    t_a[5]=4'h2; t_b[5]=4'h2; t_sel[5]=5'h05; t_sum[5]=4'h4; t_cry[5]=1'b0; t_neg[5]=1'b0; t_zero[5]=1'b0;

    rst = 1'b1; in_valid = 1'b0; in_a = 4'h0; in_b = 4'h0; in_sel = 5'h00; out_ready = 1'b0;
    force_en = 1'b0; force_sum = 4'h0; force_carry = 1'b0; force_neg = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Reset state and idle
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_zero", out_zero, 1);
    check("rst_out_sum", out_sum, 0);
    check("rst_issue", {issue_sel, issue_b, issue_a}, 0);
    check("rst_out_sel", out_sel, 0);
    check("rst_op_count", op_count, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_state", {in_ready, out_valid, issue_a}, {1'b1, 1'b0, 4'h0});
    end

    // Single operation latency
    push_req(4'h9, 4'h3, 5'h00, acc);
    in_valid = 1'b0;
    check("single_acc", acc, 1);
    check("single_early_valid", out_valid, 0);
    @(negedge clk);
    check("single_issue", {issue_sel, issue_b, issue_a}, {5'h00, 4'h3, 4'h9});
    check("single_not_yet", out_valid, 0);
    @(negedge clk);
    check("single_valid", out_valid, 1);
    check("single_sum", out_sum, 4'hC);
    check("single_flags", {out_zero, out_carry, out_neg}, 3'b000);
    check("single_sel", out_sel, 5'h00);
    out_ready = 1'b1;
    @(negedge clk);
    hs++;
    out_ready = 1'b0;
    check("single_consumed", out_valid, 0);
    check("single_count", op_count, exp_cnt(hs));

    // Zero/negative/carry flags held under stall
    force_en = 1'b1; force_sum = 4'h0; force_carry = 1'b1; force_neg = 1'b1;
    push_req(4'h5, 4'h5, 5'h07, acc);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("flag_valid", out_valid, 1);
    check("flag_bits", {out_zero, out_neg, out_carry}, 3'b111);
    check("flag_sel", out_sel, 5'h07);
    force_sum = 4'h5; force_carry = 1'b0; force_neg = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("flag_hold", {out_valid, out_zero, out_neg, out_carry, out_sum}, {4'b1111, 4'h0});
    end
    out_ready = 1'b1;
    @(negedge clk);
    hs++;
    out_ready = 1'b0;
    force_en = 1'b0;
    check("flag_count", op_count, exp_cnt(hs));

    // Backpressure: DEPTH+1 accepted, then in_ready low
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      push_req(t_a[i], t_b[i], t_sel[i], acc);
      if (acc) accepted++;
    end
    in_valid = 1'b0;
    check("bp_accepted", accepted, 5);
    check("bp_in_ready", in_ready, 0);
    check("bp_first_held", {out_valid, out_sum}, {1'b1, t_sum[0]});

    // Drain in push order, two cycles apart
    out_ready = 1'b1;
    last_cyc = cyc;
    for (int k = 0; k < 5; k++) begin
      wait_cnt = 0;
      while (!out_valid && wait_cnt < 20) begin
        @(negedge clk);
        wait_cnt++;
      end
      check("drain_valid", out_valid, 1);
      if (k > 0) check("drain_gap", cyc - last_cyc, 2);
      last_cyc = cyc;
      check("drain_sum", out_sum, t_sum[k]);
      check("drain_flags", {out_zero, out_carry, out_neg}, {t_zero[k], t_cry[k], t_neg[k]});
      check("drain_sel", out_sel, t_sel[k]);
      @(negedge clk);
      hs++;
      check("drain_count", op_count, exp_cnt(hs));
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("drain_empty", {out_valid, in_ready}, 2'b01);
    end

    // Reset while in EXEC with three entries queued
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_req(t_a[i], t_b[i], t_sel[i], acc);
    end
    in_valid = 1'b0;
    check("mid_full", in_ready, 0);
    out_ready = 1'b1;
    @(negedge clk);
    hs++;
    check("mid_in_exec", out_valid, 0);
    rst = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    hs = 0;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_issue", {issue_sel, issue_b, issue_a}, 0);
    check("mid_rst_count", op_count, exp_cnt(hs));
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("mid_no_stale", {out_valid, in_ready}, 2'b01);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
